// File: rtl/rpsc_pkg.sv
// Shared constants and helpers for the RPSC fault qualification path.
package rpsc_pkg;

  localparam int RPSC_N_CH        = 8;
  localparam int RPSC_FILT_CYCLES = 16;
  localparam int RPSC_SYNC_STAGES = 2;

  // Widest channel vector the priority helper accepts; callers zero-extend.
  localparam int RPSC_MAX_CH = 32;

  function automatic int lowest_set_idx(input logic [RPSC_MAX_CH-1:0] vec);
    int idx;
    idx = 0;
    for (int i = RPSC_MAX_CH - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rpsc_fault_filter_ch.sv
// One fault channel: input synchroniser, symmetric persistence filter,
// qualified level and sticky chatter flag.
module rpsc_fault_filter_ch #(
  parameter int FILT_CYCLES = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  input  logic clear_chatter,
  output logic fault_q,
  output logic chatter,
  output logic rise
);

  localparam int CNT_W = $clog2(FILT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   fault_d;
  logic                   chatter_q, chatter_d;
  logic                   s;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], raw_in};
    s         = sync_q[SYNC_STAGES-1];
    cnt_d     = cnt_q;
    fault_d   = fault_q;
    chatter_d = clear_chatter ? 1'b0 : chatter_q;

    if (s == fault_q) begin
      cnt_d = '0;
      // A nonzero count means a transition was in progress and just bounced back.
      if (cnt_q != '0) chatter_d = 1'b1;
    end else if (cnt_q == CNT_MAX) begin
      fault_d = s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    rise = fault_d & ~fault_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      chatter_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      chatter_q <= chatter_d;
    end
  end

  assign chatter = chatter_q;

endmodule

// File: rtl/rpsc_fault_qualifier.sv
// Qualifies raw fault comparator lines for the RPSC fault latches and
// records the first channel to trip since the last clear.
module rpsc_fault_qualifier
  import rpsc_pkg::*;
#(
  parameter int N_CH        = RPSC_N_CH,
  parameter int FILT_CYCLES = RPSC_FILT_CYCLES,
  parameter int SYNC_STAGES = RPSC_SYNC_STAGES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         raw_in,
  input  logic                    clear_first,
  output logic [N_CH-1:0]         fault_q,
  output logic                    first_fault_valid,
  output logic [$clog2(N_CH)-1:0] first_fault_id,
  output logic [N_CH-1:0]         chatter
);

  localparam int ID_W = $clog2(N_CH);

  logic [N_CH-1:0]        rise;
  logic [RPSC_MAX_CH-1:0] rise_ext;
  logic                   first_valid_q, first_valid_d;
  logic [ID_W-1:0]        first_id_q, first_id_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    rpsc_fault_filter_ch #(
      .FILT_CYCLES (FILT_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .raw_in        (raw_in[i]),
      .clear_chatter (clear_first),
      .fault_q       (fault_q[i]),
      .chatter       (chatter[i]),
      .rise          (rise[i])
    );
  end

  // Clear is applied first so a rise in the same cycle is still captured.
  always_comb begin
    rise_ext             = '0;
    rise_ext[N_CH-1:0]   = rise;
    first_valid_d        = clear_first ? 1'b0 : first_valid_q;
    first_id_d           = clear_first ? '0 : first_id_q;
    if (!first_valid_d && (rise != '0)) begin
      first_valid_d = 1'b1;
      first_id_d    = ID_W'(lowest_set_idx(rise_ext));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_valid_q <= 1'b0;
      first_id_q    <= '0;
    end else begin
      first_valid_q <= first_valid_d;
      first_id_q    <= first_id_d;
    end
  end

  assign first_fault_valid = first_valid_q;
  assign first_fault_id    = first_id_q;

endmodule

// File: doc/rpsc_fault_qualifier.md
# rpsc_fault_qualifier

Input qualification stage directly upstream of the RPSC card fault latches. It synchronises raw fault comparator lines into `clk`. Each channel is then filtered with a per-channel persistence counter, so only faults held for a programmed number of cycles reach the hold-error latches. The block also records which channel tripped first and flags chattering inputs. Its outputs feed the card's fault `*_IN` ports; `clear_first` is driven from the same source as the card's `reset_hold_error`.

## Interface
- `N_CH`, 8, number of fault channels.
- `FILT_CYCLES`, 16, consecutive synchronised cycles a new level must persist before `fault_q` follows it. Legal range ≥2.
- `SYNC_STAGES`, 2, synchroniser depth. Legal range ≥2.
- `clk`  in  1  system clock; single clock domain for all state.
- `reset`  in  1  reset, asynchronous, active-high; clears all state.
- `raw_in`  in  N_CH  raw asynchronous fault lines, active-high.
- `clear_first`  in  1  synchronous level clear for first-fault capture and chatter flags.
- `fault_q`  out  N_CH  qualified fault levels; connect to the card fault inputs.
- `first_fault_valid`  out  1  a first fault has been captured since the last clear.
- `first_fault_id`  out  $clog2(N_CH)  index of the first qualified rising channel.
- `chatter`  out  N_CH  sticky per channel; set when a pending transition was aborted.

## Operation
- Per channel, `raw_in[i]` passes through a `SYNC_STAGES` flop chain, giving `s[i]`.
- Per-channel counter `cnt[i]` has width $clog2(FILT_CYCLES). On each edge:
  - If `s[i] == fault_q[i]`: `cnt[i] <= 0`. If `cnt[i] != 0`, also set `chatter[i]` (bounce aborted a transition).
  - Else if `cnt[i] == FILT_CYCLES-1`: `fault_q[i] <= s[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i]+1`.
- Filtering is symmetric: assert and release both require `FILT_CYCLES` persistence.
- The counter never exceeds `FILT_CYCLES-1`, so there is no wrap.
- First-fault capture:
  - Define `rise = next_fault_q & ~fault_q`.
  - When `first_fault_valid == 0` (after applying any clear this cycle) and `rise != 0`: set `first_fault_valid <= 1` and `first_fault_id <=` lowest set index of `rise`.
  - While valid, further rises are ignored.
- `clear_first == 1`:
  - Clears `first_fault_valid`, `first_fault_id` and all `chatter` bits.
  - A qualifying rise in the same cycle wins: capture occurs and valid stays 1. No fault is ever lost to a clear.
  - A chatter event in the same cycle as the clear also wins: the bit ends at 1.
  - `clear_first` does not affect `fault_q` or the counters.
- `reset` asserted, at any time including mid-count: sync chains, `cnt`, `fault_q`, `chatter`, `first_fault_valid` and `first_fault_id` all go to 0 immediately. After release, filtering restarts from zero.

## Timing
- All outputs reset to 0 and are registered; there are no combinational paths from inputs to outputs.
- Assert latency: `raw_in[i]` is held high from before edge E, with `fault_q[i]` at 0. Then:
  - `s[i]` is 1 after edge `E+SYNC_STAGES-1`.
  - `fault_q[i]` rises at edge `E+SYNC_STAGES+FILT_CYCLES-1`.
  - `first_fault_valid` and `first_fault_id` update on that same edge.
- Release latency is identical.
- Any glitch on `s[i]` of fewer than `FILT_CYCLES` cycles never reaches `fault_q`.
- `clear_first` takes effect at the edge where it is sampled high.

## Structure
- The shared package `rpsc_pkg` holds:
  - the constants `RPSC_N_CH = 8`, `RPSC_FILT_CYCLES = 16` and `RPSC_SYNC_STAGES = 2`;
  - the function `lowest_set_idx`.
- Sub-module `rpsc_fault_filter_ch` contains one channel: synchroniser, counter, `fault_q` bit and chatter bit. It exports `rise` to the top level.
- The top level generates `N_CH` instances of `rpsc_fault_filter_ch` and contains the first-fault priority and capture logic.

## Test plan
All scenarios use N_CH=8, FILT_CYCLES=4, SYNC_STAGES=2.
- Reset: assert `reset` mid-run with `raw_in` = 0xFF. Required: all outputs are 0 asynchronously, before the next edge.
- Assert latency: `raw_in[3]` goes 0→1 just before edge E and is held. Required: `fault_q[3]` rises at edge E+5; `first_fault_valid` = 1 and `first_fault_id` = 3 on the same edge.
- Glitch: `raw_in[5]` is high for 3 cycles, then low. Required: `fault_q[5]` stays 0 throughout; `chatter[5]` = 1 afterwards.
- Simultaneous: `raw_in[2]` and `raw_in[6]` rise together. Required: both `fault_q` bits rise on the same edge; `first_fault_id` = 2.
- Clear versus capture:
  - With valid = 1 and id = 2, pulse `clear_first` on the edge where `fault_q[1]` rises. Required: valid = 1, id = 1.
  - Pulse `clear_first` again with no rise. Required: valid = 0, id = 0.
- Reset mid-count: `raw_in[0]` is high for 4 cycles, then `reset` is pulsed while `raw_in[0]` stays high. Required: `fault_q[0]` = 0, then rises 5 edges after the first edge following reset release.
